// File: rtl/wb_uart_tx.sv
// Wishbone B4 classic slave: buffered UART 8N1 transmitter for console output.
// Character writes to TXDATA go into a TX FIFO that drains onto tx_o. When the
// FIFO is full, the ack is withheld so that no character is dropped.
module wb_uart_tx #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr, count, count_next;
    logic          fifo_full, fifo_empty;

    logic          valid, sel_txdata, stall, ack_next, push, pop, bit_end;
    logic          fsm_active_next;
    logic [4:0]    count_field;
    logic [31:0]   rd_value;

    // Address/data bits outside the decoded fields are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

    assign valid      = wb_cyc_i & wb_stb_i;
    assign sel_txdata = (wb_adr_i[3:2] == 2'd0);
    // Full is taken from the registered flag, so a pop on the same edge only frees the slot a cycle later.
    assign stall      = valid & wb_we_i & sel_txdata & wb_sel_i[0] & fifo_full;
    assign ack_next   = valid & ~wb_ack_o & ~stall;
    assign push       = ack_next & wb_we_i & sel_txdata & wb_sel_i[0];
    assign bit_end    = (baud == BAUD_LAST);
    assign pop        = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));

    assign count      = wptr - rptr;
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // Predict whether the FSM is still framing after this edge, which busy_o needs.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        fsm_active_next = 1'b1;
        case (state)
            ST_IDLE: fsm_active_next = ~fifo_empty;
            ST_STOP: fsm_active_next = ~bit_end | ~fifo_empty;
            default: fsm_active_next = 1'b1;
        endcase
    end

    // STATUS read mux; the count field saturates when the FIFO is deeper than 31.
    always_comb begin
        count_field = (32'(count) > 32'd31) ? 5'd31 : 5'(count);
        rd_value    = '0;
        if (wb_adr_i[3:2] == 2'd1) begin
            rd_value[0]    = fifo_empty;
            rd_value[1]    = fifo_full;
            rd_value[2]    = (state != ST_IDLE);
            rd_value[12:8] = count_field;
        end
    end

    // Single-beat ack and registered read data that is valid only on the ack cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        // NOTE: sequential state uses <= so that every flop samples pre-edge values.
        if (!wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= ack_next;
            wb_dat_o <= (ack_next & ~wb_we_i) ? rd_value : '0;
        end
    end

    // FIFO pointers, registered full/empty flags and the busy indicator.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            fifo_full  <= (count_next == DEPTH);
            fifo_empty <= (count_next == '0);
            busy_o     <= fsm_active_next | (count_next != '0);
        end
    end

    // FIFO storage.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: storage has no reset; the pointers alone define which entries are valid.
        if (push) mem[wptr[AW-1:0]] <= wb_dat_i[7:0];
    end

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit, with back-to-back frames.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift <= mem[rptr[AW-1:0]];
                        tx_o  <= 1'b0;
                        baud  <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx_o    <= shift[0];
                        state   <= ST_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud  <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            tx_o  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_o    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (!fifo_empty) begin
                            shift <= mem[rptr[AW-1:0]];
                            tx_o  <= 1'b0;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed self-checking bench for wb_uart_tx. A fast instance (CLK_DIV=4) and
// a slow instance (CLK_DIV=16) share one bus; use_slow routes the cycle to one.
module tb_wb_uart_tx;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic        use_slow;

    logic        ack_f, ack_s, tx_f, tx_s, busy_f, busy_s;
    logic [31:0] dat_f, dat_s;
    logic        ack, tx, busy;
    logic [31:0] dat_r;

    int n_tests = 0;
    int n_fail  = 0;

    wb_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(16)) u_fast (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc & ~use_slow),
        .wb_stb_i (stb & ~use_slow),
        .wb_ack_o (ack_f),
        .wb_dat_o (dat_f),
        .tx_o     (tx_f),
        .busy_o   (busy_f)
    );

    wb_uart_tx #(.CLK_DIV(16), .FIFO_DEPTH(16)) u_slow (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_adr_i (adr),
        .wb_dat_i (dat_w),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc & use_slow),
        .wb_stb_i (stb & use_slow),
        .wb_ack_o (ack_s),
        .wb_dat_o (dat_s),
        .tx_o     (tx_s),
        .busy_o   (busy_s)
    );

    assign ack   = use_slow ? ack_s  : ack_f;
    assign dat_r = use_slow ? dat_s  : dat_f;
    assign tx    = use_slow ? tx_s   : tx_f;
    assign busy  = use_slow ? busy_s : busy_f;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access, started at a negedge; returns at the negedge where ack is seen.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdat, output int lat);
        adr   = a;
        dat_w = d;
        sel   = s;
        we    = w;
        cyc   = 1'b1;
        stb   = 1'b1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 2000);
        check("ack_seen", {31'd0, ack}, 32'd1);
        rdat = dat_r;
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
    endtask

    // Samples one 8N1 frame from the current negedge, one comparison per bit.
    task automatic expect_frame(input logic [7:0] b);
        int          div;
        logic [9:0]  bits;
        logic [31:0] obs, exp;
        div  = use_slow ? 16 : 4;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            obs = '0;
            for (int c = 0; c < div; c++) begin
                obs[c] = tx;
                @(negedge clk);
            end
            exp = bits[i] ? ((32'd1 << div) - 32'd1) : 32'd0;
            check($sformatf("frame_%02h_bit%0d", b, i), obs, exp);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] obs;
        int          lat;

        rst_n = 1'b0; adr = '0; dat_w = '0; sel = '0; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; use_slow = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack",     {31'd0, ack},    32'd0);
        check("rst_dat",     dat_r,           32'd0);
        check("rst_tx",      {31'd0, tx},     32'd1);
        check("rst_busy",    {31'd0, busy},   32'd0);
        check("rst_tx_slow", {31'd0, tx_s},   32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0x55
        xfer(1'b1, 32'h0, 32'h55, 4'hF, rd, lat);
        check("w55_lat", lat, 32'd1);
        check("w55_tx_ack_cycle", {31'd0, tx}, 32'd1);
        @(negedge clk);
        expect_frame(8'h55);
        check("w55_busy_end", {31'd0, busy}, 32'd0);
        check("w55_tx_end",   {31'd0, tx},   32'd1);

        // Back-to-back 'A','B' with no idle gap between frames
        xfer(1'b1, 32'h0, 32'h41, 4'hF, rd, lat);
        check("wA_lat", lat, 32'd1);
        fork
            begin
                int lat2;
                logic [31:0] rd2;
                xfer(1'b1, 32'h0, 32'h42, 4'hF, rd2, lat2);
                check("wB_lat", lat2, 32'd2);
            end
            begin
                @(negedge clk);
                expect_frame(8'h41);
                expect_frame(8'h42);
            end
        join
        check("ab_busy_end", {31'd0, busy}, 32'd0);
        check("ab_tx_end",   {31'd0, tx},   32'd1);

        // STATUS with 3 queued and a frame in flight
        xfer(1'b1, 32'h0, 32'hA1, 4'hF, rd, lat);
        xfer(1'b1, 32'h0, 32'hA2, 4'hF, rd, lat);
        xfer(1'b1, 32'h0, 32'hA3, 4'hF, rd, lat);
        xfer(1'b1, 32'h0, 32'hA4, 4'hF, rd, lat);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        check("st3_lat", lat, 32'd2);
        check("st3_val", rd, 32'h0000_0304);
        @(negedge clk);
        check("st3_dat_after", dat_r, 32'd0);
        wait_idle(400);

        // Partial-select write: acked, no push
        @(negedge clk);
        xfer(1'b1, 32'h0, 32'h0000_00FF, 4'b1110, rd, lat);
        check("sel_lat", lat, 32'd1);
        obs = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs[c] = tx;
        end
        check("sel_tx_high", obs, 32'h0000_00FF);
        check("sel_busy", {31'd0, busy}, 32'd0);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        check("sel_status", rd, 32'h0000_0001);

        // Reads of TXDATA and reserved words, and an ignored STATUS write
        @(negedge clk);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
        check("rd_txdata", rd, 32'd0);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
        check("rd_rsv8", rd, 32'd0);
        xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat);
        check("rd_rsvC", rd, 32'd0);
        xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, rd, lat);
        xfer(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, rd, lat);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        check("status_after_wr", rd, 32'h0000_0001);
        check("status_wr_busy", {31'd0, busy}, 32'd0);

        // FIFO overflow backpressure on the CLK_DIV=16 instance
        @(negedge clk);
        use_slow = 1'b1;
        @(negedge clk);
        xfer(1'b1, 32'h0, 32'h00, 4'hF, rd, lat);
        check("ovf_w0_lat", lat, 32'd1);
        fork
            begin
                int          lw;
                logic [31:0] rw;
                for (int k = 1; k <= 16; k++) begin
                    xfer(1'b1, 32'h0, 32'(k), 4'hF, rw, lw);
                    check($sformatf("ovf_w%0d_lat", k), lw, 32'd2);
                end
                xfer(1'b0, 32'h4, 32'h0, 4'hF, rw, lw);
                check("ovf_status_full", rw, 32'h0000_1006);
                xfer(1'b1, 32'h0, 32'h11, 4'hF, rw, lw);
                check("ovf_w17_stall_lat", lw, 32'd128);
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 18; k++) expect_frame(8'(k));
            end
        join
        check("ovf_busy_end", {31'd0, busy}, 32'd0);
        use_slow = 1'b0;
        @(negedge clk);

        // Asynchronous reset during DATA bit 3 of 0xF0 (bit 3 is a 0)
        xfer(1'b1, 32'h0, 32'hF0, 4'hF, rd, lat);
        repeat (18) @(negedge clk);
        check("pre_rst_tx_low", {31'd0, tx},   32'd0);
        check("pre_rst_busy",   {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx",   {31'd0, tx},   32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_hold_tx", {31'd0, tx}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        check("post_rst_status", rd, 32'h0000_0001);
        @(negedge clk);
        xfer(1'b1, 32'h0, 32'h3C, 4'hF, rd, lat);
        check("post_rst_w_lat", lat, 32'd1);
        @(negedge clk);
        expect_frame(8'h3C);
        check("post_rst_busy_end", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
